// File: rtl/dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dma_arbiter
//  Function : Round-robin arbiter granting N_REQ DMA requesters bursts of up
//             to BURST_MAX beats on one shared single-port memory interface.
//             Each burst is followed by a one-cycle TURN gap, and read data
//             is returned to the owning requester one cycle after each read.
//  Revision : 1.0 - initial release
// ============================================================================
module dma_arbiter #(
  parameter int N_REQ     = 3,
  parameter int BURST_MAX = 16
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic [N_REQ-1:0]     REQ_req,
  input  logic [16*N_REQ-1:0]  REQ_addr,
  input  logic [16*N_REQ-1:0]  REQ_data,
  input  logic [N_REQ-1:0]     REQ_wren,
  output logic [N_REQ-1:0]     REQ_gnt,
  output logic [15:0]          REQ_q,
  output logic [N_REQ-1:0]     REQ_qvalid,
  output logic [15:0]          DMA_addr,
  output logic [15:0]          DMA_data,
  output logic                 DMA_wren,
  input  logic [15:0]          DMA_q
);

  // Requester index width; N_REQ is limited to 2..4
  localparam int              c_PW   = (N_REQ > 2) ? 2 : 1;
  localparam logic [c_PW-1:0] c_LAST = c_PW'(N_REQ - 1);
  localparam logic [8:0]      c_BMAX = 9'(BURST_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t            r_state;
  logic [N_REQ-1:0]  r_gnt;
  logic [N_REQ-1:0]  r_qvalid;
  logic [c_PW-1:0]   r_ptr;
  logic [c_PW-1:0]   r_idx;
  logic [8:0]        r_beat;

  logic              w_sel_any;
  logic [c_PW-1:0]   w_sel_idx;
  logic [N_REQ-1:0]  w_sel_oh;
  logic [N_REQ-1:0]  w_idx_oh;
  logic              w_beat;
  logic [15:0]       w_addr;
  logic [15:0]       w_data;
  logic              w_wren;

  // Round-robin pick: first requesting line at or above r_ptr, wrapping.
  // The scan runs from the farthest offset down so the nearest one wins.
  always_comb begin
    w_sel_any = 1'b0;
    w_sel_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(r_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (REQ_req[j[c_PW-1:0]]) begin
        w_sel_any = 1'b1;
        w_sel_idx = j[c_PW-1:0];
      end
    end
  end

  // One-hot forms of the candidate and of the currently granted requester
  always_comb begin
    w_sel_oh            = '0;
    w_sel_oh[w_sel_idx] = 1'b1;
    w_idx_oh            = '0;
    w_idx_oh[r_idx]     = 1'b1;
  end

  // Route the granted requester's access fields toward the memory port
  always_comb begin
    w_addr = '0;
    w_data = '0;
    w_wren = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_idx == c_PW'(i)) begin
        w_addr = REQ_addr[16*i +: 16];
        w_data = REQ_data[16*i +: 16];
        w_wren = REQ_wren[i];
      end
    end
  end

  // A beat is a granted cycle in which the owner still requests
  assign w_beat   = (r_state == S_BURST) && REQ_req[r_idx];

  // Memory port is quiet (all zero) on every non-beat cycle
  assign DMA_addr = w_beat ? w_addr : 16'h0000;
  assign DMA_data = w_beat ? w_data : 16'h0000;
  assign DMA_wren = w_beat & w_wren;

  // Read data is broadcast raw; REQ_qvalid alone says who owns it
  assign REQ_q      = DMA_q;
  assign REQ_gnt    = r_gnt;
  assign REQ_qvalid = r_qvalid;

  // Arbitration FSM: IDLE picks, BURST counts beats, TURN advances pointer
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_qvalid <= '0;
      r_ptr    <= '0;
      r_idx    <= '0;
      r_beat   <= '0;
    end else begin
      // Memory answers a read one cycle later, so flag the owner then
      r_qvalid <= (w_beat && !w_wren) ? w_idx_oh : '0;
      case (r_state)
        S_IDLE: begin
          if (w_sel_any) begin
            r_state <= S_BURST;
            r_gnt   <= w_sel_oh;
            r_idx   <= w_sel_idx;
            r_beat  <= '0;
          end
        end
        S_BURST: begin
          if (!REQ_req[r_idx]) begin
            r_state <= S_TURN;
            r_gnt   <= '0;
          end else begin
            r_beat <= r_beat + 9'd1;
            if (r_beat + 9'd1 == c_BMAX) begin
              r_state <= S_TURN;
              r_gnt   <= '0;
            end
          end
        end
        S_TURN: begin
          r_state <= S_IDLE;
          r_ptr   <= (r_idx == c_LAST) ? '0 : r_idx + c_PW'(1);
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dma_arbiter
//  Function : Scoreboard bench for dma_arbiter. Directed stimulus pushes
//             expected grants, memory accesses and read returns into queues;
//             negedge monitors pop and compare as the DUT presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dma_arbiter;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
    logic        w;
  } acc_t;

  typedef struct {
    int idx;
    int cyc;
    int beats;
  } gexp_t;

  typedef struct {
    int          cyc;
    logic [2:0]  g;
    logic [15:0] a;
  } bexp_t;

  // Main instance (defaults) signals
  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [2:0]  REQ_req;
  logic [47:0] REQ_addr;
  logic [47:0] REQ_data;
  logic [2:0]  REQ_wren;
  logic [2:0]  REQ_gnt;
  logic [15:0] REQ_q;
  logic [2:0]  REQ_qvalid;
  logic [15:0] DMA_addr;
  logic [15:0] DMA_data;
  logic        DMA_wren;
  logic [15:0] DMA_q = 16'h0000;

  // Second instance with BURST_MAX = 1
  logic        RESET_B;
  logic [2:0]  req_b  = 3'b101;
  logic [47:0] addr_in_b = {16'h0C0C, 16'h0B0B, 16'h0A0A};
  logic [47:0] data_in_b = 48'h0;
  logic [2:0]  wren_in_b = 3'b000;
  logic [15:0] dq_b = 16'h0000;
  logic [2:0]  gnt_b;
  logic [15:0] q_b;
  logic [2:0]  qv_b;
  logic [15:0] addr_b;
  logic [15:0] data_b;
  logic        wren_b;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int wcount = 0;
  bit mon_en = 1'b0;

  // Requester driver state
  logic [15:0] base [3];
  logic [15:0] dat  [3];
  logic        wr   [3];
  int          lim  [3];
  int          cnt  [3];

  acc_t  exp_acc [3][$];
  logic [15:0] exp_rd [3][$];
  gexp_t exp_gnt [$];
  bexp_t exp_b [$];

  dma_arbiter #(.N_REQ(3), .BURST_MAX(16)) u_dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .REQ_req(REQ_req), .REQ_addr(REQ_addr), .REQ_data(REQ_data), .REQ_wren(REQ_wren),
    .REQ_gnt(REQ_gnt), .REQ_q(REQ_q), .REQ_qvalid(REQ_qvalid),
    .DMA_addr(DMA_addr), .DMA_data(DMA_data), .DMA_wren(DMA_wren), .DMA_q(DMA_q)
  );

  dma_arbiter #(.N_REQ(3), .BURST_MAX(1)) u_dut_b (
    .CLOCK(CLOCK), .RESET(RESET_B),
    .REQ_req(req_b), .REQ_addr(addr_in_b), .REQ_data(data_in_b), .REQ_wren(wren_in_b),
    .REQ_gnt(gnt_b), .REQ_q(q_b), .REQ_qvalid(qv_b),
    .DMA_addr(addr_b), .DMA_data(data_b), .DMA_wren(wren_b), .DMA_q(dq_b)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Memory model: registered read, contents = address ^ 5A5A
  always @(posedge CLOCK) DMA_q <= DMA_addr ^ 16'h5A5A;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Start a requester plan: l beats from base b, then drop the request
  task automatic plan(input int i, input logic [15:0] b, input logic w,
                      input logic [15:0] d, input int l);
    acc_t e;
    base[i] = b; wr[i] = w; dat[i] = d; lim[i] = l; cnt[i] = 0;
    exp_acc[i].delete();
    REQ_addr[16*i +: 16] = b;
    REQ_data[16*i +: 16] = d;
    REQ_wren[i] = w;
    REQ_req[i]  = 1'b1;
    e.a = b; e.d = d; e.w = w;
    exp_acc[i].push_back(e);
  endtask

  // Advance one cycle; requesters step their address after each beat
  task automatic tick();
    logic [2:0] b;
    logic rs;
    b  = REQ_gnt & REQ_req;
    rs = RESET;
    @(posedge CLOCK); #1;
    for (int i = 0; i < 3; i++) begin
      if (b[i]) begin
        logic [15:0] a;
        acc_t e;
        a = base[i] + 16'(cnt[i]);
        if (!rs && !wr[i]) exp_rd[i].push_back(a ^ 16'h5A5A);
        cnt[i]++;
        if (cnt[i] >= lim[i]) begin
          REQ_req[i] = 1'b0;
        end else begin
          a = base[i] + 16'(cnt[i]);
          REQ_addr[16*i +: 16] = a;
          e.a = a; e.d = dat[i]; e.w = wr[i];
          exp_acc[i].push_back(e);
        end
      end
    end
  endtask

  task automatic push_g(input int idx, input int c, input int beats);
    gexp_t g;
    g.idx = idx; g.cyc = c; g.beats = beats;
    exp_gnt.push_back(g);
  endtask

  task automatic do_reset();
    REQ_req = 3'b000;
    RESET   = 1'b1;
    tick();
    RESET   = 1'b0;
  endtask

  task automatic drain(input string nm);
    chk({nm, "_gnt_left"}, exp_gnt.size(), 0);
    chk({nm, "_rd_left"}, exp_rd[0].size() + exp_rd[1].size() + exp_rd[2].size(), 0);
    chk({nm, "_acc_left"}, exp_acc[0].size() + exp_acc[1].size() + exp_acc[2].size(), 0);
    chk({nm, "_gnt_idle"}, REQ_gnt, 3'b000);
  endtask

  // Main monitor: grants, accesses, idle port, read returns
  logic [2:0] prev_gnt = 3'b000;
  logic [2:0] prev_rd  = 3'b000;
  int beats = 0;
  int cur_beats_exp = 0;

  always @(negedge CLOCK) begin
    if (mon_en) begin
      logic [2:0] bt;
      int bi;
      gexp_t g;
      acc_t e;
      bt = REQ_gnt & REQ_req;
      bi = 0;
      for (int i = 0; i < 3; i++) if (REQ_gnt[i]) bi = i;
      if (REQ_gnt != 3'b000 && prev_gnt == 3'b000) begin
        if (exp_gnt.size() == 0) begin
          chk("gnt_unexpected", REQ_gnt, 3'b000);
        end else begin
          g = exp_gnt.pop_front();
          chk("gnt_idx", bi, g.idx);
          chk("gnt_cycle", cyc, g.cyc);
          cur_beats_exp = g.beats;
        end
        beats = 0;
      end
      if (REQ_gnt == 3'b000 && prev_gnt != 3'b000) chk("burst_beats", beats, cur_beats_exp);
      if (bt != 3'b000) begin
        beats++;
        if (exp_acc[bi].size() == 0) begin
          chk("acc_unexpected", DMA_addr, 16'h0000);
        end else begin
          e = exp_acc[bi].pop_front();
          chk("dma_addr", DMA_addr, e.a);
          chk("dma_data", DMA_data, e.d);
          chk("dma_wren", DMA_wren, e.w);
        end
        if (DMA_wren) wcount++;
      end else begin
        chk("quiet_port", {DMA_wren, DMA_addr, DMA_data}, 33'h0);
      end
      chk("qvalid", REQ_qvalid, prev_rd);
      for (int i = 0; i < 3; i++) begin
        if (REQ_qvalid[i]) begin
          if (exp_rd[i].size() == 0) chk("rd_unexpected", i, 7);
          else chk("rd_data", REQ_q, exp_rd[i].pop_front());
        end
      end
      prev_rd  = (bt != 3'b000 && !DMA_wren && !RESET) ? REQ_gnt : 3'b000;
      prev_gnt = REQ_gnt;
    end
  end

  // Monitor for the single-beat instance
  always @(negedge CLOCK) begin
    if (exp_b.size() > 0 && exp_b[0].cyc == cyc) begin
      bexp_t x;
      x = exp_b.pop_front();
      chk("b_gnt", gnt_b, x.g);
      chk("b_addr", addr_b, x.a);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t0;
    int t1;
    RESET = 1'b1; RESET_B = 1'b1;
    REQ_req = '0; REQ_addr = '0; REQ_data = '0; REQ_wren = '0;
    for (int i = 0; i < 3; i++) begin
      base[i] = '0; dat[i] = '0; wr[i] = 1'b0; lim[i] = 0; cnt[i] = 0;
    end
    repeat (3) tick();

    // Reset state
    @(negedge CLOCK);
    chk("rst_gnt", REQ_gnt, 3'b000);
    chk("rst_qvalid", REQ_qvalid, 3'b000);
    chk("rst_wren", DMA_wren, 1'b0);
    chk("rst_b_gnt", gnt_b, 3'b000);
    tick();
    RESET  = 1'b0;
    mon_en = 1'b1;

    // Single requester reads: 16-beat burst, TURN, IDLE, regrant
    t0 = cyc;
    plan(0, 16'hF000, 1'b0, 16'h0000, 17);
    push_g(0, t0 + 1, 16);
    push_g(0, t0 + 19, 1);
    repeat (24) tick();
    drain("solo");

    // All three request: order 0,1,2,0 with an 18-cycle period
    do_reset();
    t0 = cyc;
    plan(0, 16'h1000, 1'b0, 16'h0000, 32);
    plan(1, 16'h2100, 1'b0, 16'h0000, 16);
    plan(2, 16'h3200, 1'b0, 16'h0000, 16);
    push_g(0, t0 + 1, 16);
    push_g(1, t0 + 19, 16);
    push_g(2, t0 + 37, 16);
    push_g(0, t0 + 55, 16);
    repeat (76) tick();
    drain("rr");

    // Requester 1 writes four words, then ptr should point at 2
    do_reset();
    wcount = 0;
    t0 = cyc;
    plan(1, 16'h8000, 1'b1, 16'hAAAA, 4);
    push_g(1, t0 + 1, 4);
    repeat (8) tick();
    chk("write_cycles", wcount, 4);
    t1 = cyc;
    plan(0, 16'h1100, 1'b0, 16'h0000, 1);
    plan(1, 16'h2200, 1'b0, 16'h0000, 1);
    plan(2, 16'h3300, 1'b0, 16'h0000, 1);
    push_g(2, t1 + 1, 1);
    push_g(0, t1 + 5, 1);
    push_g(1, t1 + 9, 1);
    repeat (14) tick();
    drain("write");

    // Reset on beat 5 of a read burst by requester 2
    do_reset();
    t0 = cyc;
    plan(2, 16'hC000, 1'b0, 16'h0000, 32);
    push_g(2, t0 + 1, 5);
    repeat (5) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    t1 = cyc;
    plan(0, 16'h4000, 1'b0, 16'h0000, 1);
    plan(1, 16'h5000, 1'b0, 16'h0000, 1);
    plan(2, 16'h6000, 1'b0, 16'h0000, 1);
    push_g(0, t1 + 1, 1);
    push_g(1, t1 + 5, 1);
    push_g(2, t1 + 9, 1);
    repeat (14) tick();
    drain("abort");

    // BURST_MAX = 1 instance with requests 101: grants 0,2,0,2
    RESET_B = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 12; k++) begin
      bexp_t x;
      x.cyc = t0 + 1 + k;
      if (k % 6 == 0) begin
        x.g = 3'b001; x.a = 16'h0A0A;
      end else if (k % 6 == 3) begin
        x.g = 3'b100; x.a = 16'h0C0C;
      end else begin
        x.g = 3'b000; x.a = 16'h0000;
      end
      exp_b.push_back(x);
    end
    repeat (14) tick();
    chk("b_left", exp_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
